// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared types for the unified memory port arbiter: FSM state encodings
//   and the width of the fetch starvation counter.
package mem_port_arbiter_pkg;

    localparam int unsigned STARVE_CNT_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_IF_BUSY = 2'b01,
        ARB_DM_BUSY = 2'b10
    } arb_state_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr
//   Saturating up-counter that tracks how many consecutive cycles a fetch
//   has been denied the memory port. sat tells the arbiter that fetch must
//   now beat a data request.
// Ports
//   clock  in   system clock
//   reset  in   asynchronous active-high reset
//   inc    in   count one denied cycle
//   clr    in   restart the count (fetch granted, withdrawn or flushed)
//   sat    out  count has reached STARVE_MAX
module arb_starve_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [STARVE_CNT_W-1:0] CNT_MAX = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q < CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between instruction fetch (IF) and the
//   MEM stage. One requester is granted at a time from IDLE; the registered
//   req/ack transaction completes with a one-cycle valid pulse back to the
//   requester. Data accesses win unless fetch has been starved STARVE_MAX
//   cycles in a row.
//
//   state       | meaning
//   ------------+-----------------------------------------------
//   ARB_IDLE    | port free, grant decision made this cycle
//   ARB_IF_BUSY | fetch transaction outstanding, wait for mem_ack
//   ARB_DM_BUSY | load/store transaction outstanding, wait for mem_ack
//
// Ports
//   clock, reset                  clock and async active-high reset
//   if_req/if_addr/if_flush       fetch request, PC, squash
//   if_rdata/if_valid             fetched word and completion pulse
//   dm_read/dm_write/dm_addr/
//   dm_wdata                      load/store request from MEM stage
//   dm_rdata/dm_valid             load data and completion pulse
//   stall_if/stall_mem            combinational stalls to hazard logic
//   mem_req/mem_we/mem_addr/
//   mem_wdata                     registered memory request
//   mem_rdata/mem_ack             memory response
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    arb_state_e        state_q, state_d;
    logic              drop_q, drop_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              dm_valid_q, dm_valid_d;

    logic dm_pend;
    logic if_cand;
    logic is_idle;
    logic dm_grant;
    logic if_grant;
    logic ack_if;
    logic ack_dm;
    logic starve_inc;
    logic starve_clr;
    logic starve_sat;

    // A request whose valid is high this cycle has already been served; the
    // requester drops it at the next edge, so it must not be re-granted.
    assign dm_pend = (dm_read | dm_write) & ~dm_valid_q;
    assign if_cand = if_req & ~if_valid_q & ~if_flush;
    assign is_idle = (state_q == ARB_IDLE);

    assign dm_grant = is_idle & dm_pend & (~starve_sat | ~if_cand);
    assign if_grant = is_idle & if_cand & ~dm_grant;

    assign ack_if = (state_q == ARB_IF_BUSY) & mem_ack;
    assign ack_dm = (state_q == ARB_DM_BUSY) & mem_ack;

    // An in-flight fetch is not "denied", so it does not age the counter.
    assign starve_inc = if_cand & ~if_grant & (state_q != ARB_IF_BUSY);
    assign starve_clr = ~if_req | if_flush | if_grant;

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clock (clock),
        .reset (reset),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .sat   (starve_sat)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (dm_grant) begin
                    state_d = ARB_DM_BUSY;
                end else if (if_grant) begin
                    state_d = ARB_IF_BUSY;
                end
            end
            ARB_IF_BUSY: begin
                if (mem_ack) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_DM_BUSY: begin
                if (mem_ack) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        drop_d      = drop_q;

        if (dm_grant) begin
            mem_req_d   = 1'b1;
            mem_we_d    = dm_write;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
        end else if (if_grant) begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr;
        end

        if (ack_if || ack_dm) begin
            mem_req_d = 1'b0;
        end

        // A flush while the fetch is in flight cannot cancel the memory
        // access; it only suppresses the result when the ack arrives.
        if (ack_if) begin
            drop_d = 1'b0;
            if (!drop_q && !if_flush) begin
                if_rdata_d = mem_rdata;
                if_valid_d = 1'b1;
            end
        end else if ((state_q == ARB_IF_BUSY) && if_flush) begin
            drop_d = 1'b1;
        end

        if (ack_dm) begin
            dm_valid_d = 1'b1;
            if (!mem_we_q) begin
                dm_rdata_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_rdata_q  <= '0;
            dm_valid_q  <= 1'b0;
        end else begin
            drop_q      <= drop_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_rdata_q  <= dm_rdata_d;
            dm_valid_q  <= dm_valid_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_valid  = dm_valid_q;

    assign stall_if  = if_req & ~if_valid_q & ~if_flush;
    assign stall_mem = (dm_read | dm_write) & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed, table-driven bench. Each vector holds the inputs for one
//   cycle, the expected combinational stalls during that cycle and the
//   expected registered state after the following rising edge.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int unsigned SMAX = 2;
    localparam logic [1:0] S_I = 2'd0;
    localparam logic [1:0] S_F = 2'd1;
    localparam logic [1:0] S_D = 2'd2;

    logic        clock;
    logic        reset;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_flush;
    logic [63:0] if_rdata;
    logic        if_valid;
    logic        dm_read;
    logic        dm_write;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic [63:0] dm_rdata;
    logic        dm_valid;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;

    int n_chk  = 0;
    int n_pass = 0;

    mem_port_arbiter #(
        .ADDR_W     (64),
        .DATA_W     (64),
        .STARVE_MAX (SMAX)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .dm_read   (dm_read),
        .dm_write  (dm_write),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_valid  (dm_valid),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        dr, dw, ir, fl, ack;
        logic [63:0] rdata;
        logic        sif, smem;
        logic [1:0]  st;
        logic        req, we;
        logic [63:0] addr;
        logic        ifv, dmv;
        logic [63:0] ifd, dmd;
        logic [3:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic dr, input logic dw, input logic ir, input logic fl,
        input logic ack, input logic [63:0] rdata,
        input logic sif, input logic smem, input logic [1:0] st,
        input logic req, input logic we, input logic [63:0] addr,
        input logic ifv, input logic dmv,
        input logic [63:0] ifd, input logic [63:0] dmd, input logic [3:0] cnt);
        vec_t v;
        v.dr = dr; v.dw = dw; v.ir = ir; v.fl = fl; v.ack = ack;
        v.rdata = rdata; v.sif = sif; v.smem = smem; v.st = st;
        v.req = req; v.we = we; v.addr = addr; v.ifv = ifv; v.dmv = dmv;
        v.ifd = ifd; v.dmd = dmd; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int pulses;

        // Load, ack tied high
        vecs.push_back(mk(1,0,0,0,1,64'hDEAD, 0,1,S_D,1,0,64'h40,  0,0,64'h0,64'h0,   0));
        vecs.push_back(mk(1,0,0,0,1,64'hDEAD, 0,1,S_I,0,0,64'h40,  0,1,64'h0,64'hDEAD,0));
        vecs.push_back(mk(1,0,0,0,1,64'hDEAD, 0,0,S_I,0,0,64'h40,  0,0,64'h0,64'hDEAD,0));
        vecs.push_back(mk(0,0,0,0,1,64'hDEAD, 0,0,S_I,0,0,64'h40,  0,0,64'h0,64'hDEAD,0));
        // Store and fetch together: store first, fetch in next IDLE
        vecs.push_back(mk(0,1,1,0,1,64'h1111, 1,1,S_D,1,1,64'h40,  0,0,64'h0,64'hDEAD,1));
        vecs.push_back(mk(0,1,1,0,1,64'h1111, 1,1,S_I,0,1,64'h40,  0,1,64'h0,64'hDEAD,2));
        vecs.push_back(mk(0,1,1,0,1,64'h2222, 1,0,S_F,1,0,64'h1000,0,0,64'h0,64'hDEAD,0));
        vecs.push_back(mk(0,0,1,0,1,64'h2222, 1,0,S_I,0,0,64'h1000,1,0,64'h2222,64'hDEAD,0));
        vecs.push_back(mk(0,0,1,0,1,64'h2222, 0,0,S_I,0,0,64'h1000,0,0,64'h2222,64'hDEAD,0));
        vecs.push_back(mk(0,0,0,0,1,64'h2222, 0,0,S_I,0,0,64'h1000,0,0,64'h2222,64'hDEAD,0));
        // Continuous load traffic with pending fetch, counter saturates at 2
        vecs.push_back(mk(1,0,1,0,0,64'h3333, 1,1,S_D,1,0,64'h40,  0,0,64'h2222,64'hDEAD,1));
        vecs.push_back(mk(1,0,1,0,0,64'h3333, 1,1,S_D,1,0,64'h40,  0,0,64'h2222,64'hDEAD,2));
        vecs.push_back(mk(1,0,1,0,0,64'h3333, 1,1,S_D,1,0,64'h40,  0,0,64'h2222,64'hDEAD,2));
        vecs.push_back(mk(1,0,1,0,1,64'h3333, 1,1,S_I,0,0,64'h40,  0,1,64'h2222,64'h3333,2));
        vecs.push_back(mk(1,0,1,0,0,64'h4444, 1,0,S_F,1,0,64'h1000,0,0,64'h2222,64'h3333,0));
        vecs.push_back(mk(1,0,1,0,1,64'h4444, 1,1,S_I,0,0,64'h1000,1,0,64'h4444,64'h3333,0));
        vecs.push_back(mk(1,0,1,0,1,64'h5555, 0,1,S_D,1,0,64'h40,  0,0,64'h4444,64'h3333,0));
        vecs.push_back(mk(1,0,0,0,1,64'h5555, 0,1,S_I,0,0,64'h40,  0,1,64'h4444,64'h5555,0));
        vecs.push_back(mk(0,0,0,0,1,64'h5555, 0,0,S_I,0,0,64'h40,  0,0,64'h4444,64'h5555,0));
        // Flush in IDLE blocks grant; flush in IF_BUSY drops the result
        vecs.push_back(mk(0,0,1,1,1,64'h6666, 0,0,S_I,0,0,64'h40,  0,0,64'h4444,64'h5555,0));
        vecs.push_back(mk(0,0,1,0,0,64'h6666, 1,0,S_F,1,0,64'h1000,0,0,64'h4444,64'h5555,0));
        vecs.push_back(mk(0,0,1,1,0,64'h6666, 0,0,S_F,1,0,64'h1000,0,0,64'h4444,64'h5555,0));
        vecs.push_back(mk(0,0,1,0,0,64'h6666, 1,0,S_F,1,0,64'h1000,0,0,64'h4444,64'h5555,0));
        vecs.push_back(mk(0,0,1,0,1,64'h6666, 1,0,S_I,0,0,64'h1000,0,0,64'h4444,64'h5555,0));
        vecs.push_back(mk(0,0,1,0,1,64'h7777, 1,0,S_F,1,0,64'h1000,0,0,64'h4444,64'h5555,0));
        vecs.push_back(mk(0,0,1,0,1,64'h7777, 1,0,S_I,0,0,64'h1000,1,0,64'h7777,64'h5555,0));
        vecs.push_back(mk(0,0,1,0,1,64'h7777, 0,0,S_I,0,0,64'h1000,0,0,64'h7777,64'h5555,0));
        vecs.push_back(mk(0,0,0,0,1,64'h7777, 0,0,S_I,0,0,64'h1000,0,0,64'h7777,64'h5555,0));

        reset     = 1'b1;
        if_req    = 1'b0;
        if_addr   = 64'h1000;
        if_flush  = 1'b0;
        dm_read   = 1'b0;
        dm_write  = 1'b0;
        dm_addr   = 64'h40;
        dm_wdata  = 64'hBEEF;
        mem_rdata = 64'h0;
        mem_ack   = 1'b0;

        step();
        step();
        chk("rst.mem_req",   {63'd0, mem_req},   64'd0);
        chk("rst.mem_we",    {63'd0, mem_we},    64'd0);
        chk("rst.mem_addr",  mem_addr,           64'd0);
        chk("rst.mem_wdata", mem_wdata,          64'd0);
        chk("rst.if_rdata",  if_rdata,           64'd0);
        chk("rst.if_valid",  {63'd0, if_valid},  64'd0);
        chk("rst.dm_rdata",  dm_rdata,           64'd0);
        chk("rst.dm_valid",  {63'd0, dm_valid},  64'd0);
        chk("rst.state",     {62'd0, dut.state_q}, {62'd0, S_I});
        chk("rst.cnt",       {60'd0, dut.u_starve.cnt_q}, 64'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            dm_read   = vecs[i].dr;
            dm_write  = vecs[i].dw;
            if_req    = vecs[i].ir;
            if_flush  = vecs[i].fl;
            mem_ack   = vecs[i].ack;
            mem_rdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d.stall_if", i),  {63'd0, stall_if},  {63'd0, vecs[i].sif});
            chk($sformatf("v%0d.stall_mem", i), {63'd0, stall_mem}, {63'd0, vecs[i].smem});
            step();
            chk($sformatf("v%0d.state", i),    {62'd0, dut.state_q}, {62'd0, vecs[i].st});
            chk($sformatf("v%0d.mem_req", i),  {63'd0, mem_req},  {63'd0, vecs[i].req});
            chk($sformatf("v%0d.mem_we", i),   {63'd0, mem_we},   {63'd0, vecs[i].we});
            chk($sformatf("v%0d.mem_addr", i), mem_addr,          vecs[i].addr);
            chk($sformatf("v%0d.if_valid", i), {63'd0, if_valid}, {63'd0, vecs[i].ifv});
            chk($sformatf("v%0d.dm_valid", i), {63'd0, dm_valid}, {63'd0, vecs[i].dmv});
            chk($sformatf("v%0d.if_rdata", i), if_rdata,          vecs[i].ifd);
            chk($sformatf("v%0d.dm_rdata", i), dm_rdata,          vecs[i].dmd);
            chk($sformatf("v%0d.cnt", i),      {60'd0, dut.u_starve.cnt_q}, {60'd0, vecs[i].cnt});
        end

        // Wait states: store with ack held off 5 cycles; request inputs
        // change underneath but the latched memory request must not.
        dm_write  = 1'b1;
        dm_addr   = 64'h88;
        dm_wdata  = 64'hCAFE;
        mem_ack   = 1'b0;
        mem_rdata = 64'h9999;
        pulses    = 0;
        step();
        chk("ws.grant_req", {63'd0, mem_req}, 64'd1);
        chk("ws.grant_we",  {63'd0, mem_we},  64'd1);
        dm_addr  = 64'hFFFF;
        dm_wdata = 64'h0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("ws%0d.mem_req", k),   {63'd0, mem_req}, 64'd1);
            chk($sformatf("ws%0d.mem_we", k),    {63'd0, mem_we},  64'd1);
            chk($sformatf("ws%0d.mem_addr", k),  mem_addr,         64'h88);
            chk($sformatf("ws%0d.mem_wdata", k), mem_wdata,        64'hCAFE);
            if (dm_valid) pulses++;
        end
        mem_ack = 1'b1;
        step();
        if (dm_valid) pulses++;
        chk("ws.store_rdata_kept", dm_rdata, 64'h5555);
        dm_write = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (dm_valid) pulses++;
        end
        chk("ws.valid_pulses", 64'(pulses), 64'd1);
        chk("ws.req_dropped",  {63'd0, mem_req}, 64'd0);

        // Reset in the middle of a load with no ack
        mem_ack = 1'b0;
        dm_read = 1'b1;
        dm_addr = 64'h40;
        step();
        chk("rm.busy_req",   {63'd0, mem_req}, 64'd1);
        chk("rm.busy_state", {62'd0, dut.state_q}, {62'd0, S_D});
        #2;
        reset = 1'b1;
        #1;
        chk("rm.async_req",   {63'd0, mem_req}, 64'd0);
        chk("rm.async_state", {62'd0, dut.state_q}, {62'd0, S_I});
        step();
        reset   = 1'b0;
        dm_read = 1'b0;
        mem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("rm%0d.dm_valid", k), {63'd0, dm_valid}, 64'd0);
            chk($sformatf("rm%0d.mem_req", k),  {63'd0, mem_req},  64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
